// File: rtl/clsf_vote_ensemble.sv
// Ensemble vote aggregator: collects one result bit per enabled tree, tolerating skewed
// per-tree latency, then combines them by a latched vote mode with a timeout guard.
module clsf_vote_ensemble #(
  parameter int unsigned NUM_TREES = 18,
  parameter int unsigned TIMEOUT   = 64,
  localparam int unsigned CNT_W    = $clog2(NUM_TREES + 1),
  localparam int unsigned TMO_W    = $clog2(TIMEOUT)
) (
  input  logic                 rx_fifo_clock,
  input  logic                 rx_fifo_resetn,
  input  logic                 start,
  input  logic [NUM_TREES-1:0] tree_en,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     threshold,
  input  logic [NUM_TREES-1:0] tree_valid,
  input  logic [NUM_TREES-1:0] tree_result,
  output logic                 busy,
  output logic                 vote_valid,
  output logic                 vote_result,
  output logic [CNT_W-1:0]     vote_count,
  output logic                 timeout_err,
  output logic                 start_drop
);

  typedef enum logic [1:0] {StIdle, StCollect, StEval} state_e;

  state_e               state_q, state_d;
  logic [NUM_TREES-1:0] en_q, en_d, got_q, got_d, res_q, res_d;
  logic [1:0]           mode_q, mode_d;
  logic [CNT_W-1:0]     thr_q, thr_d;
  logic [TMO_W-1:0]     timer_q, timer_d;
  logic                 vote_valid_q, vote_valid_d, vote_result_q, vote_result_d;
  logic [CNT_W-1:0]     vote_count_q, vote_count_d;
  logic                 timeout_err_q, timeout_err_d, start_drop_q, start_drop_d;

  logic [NUM_TREES-1:0] capture;
  logic                 coll_done;
  logic [CNT_W-1:0]     cnt, n_en;
  logic                 decision;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_TREES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_TREES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Only the first valid of an enabled tree is kept; repeats and disabled trees are ignored.
  assign capture   = tree_valid & en_q & ~got_q;
  assign coll_done = (got_q == en_q) || (timer_q == TMO_W'(TIMEOUT - 1));
  assign cnt       = popcnt(res_q & en_q);
  assign n_en      = popcnt(en_q);

  always_comb begin
    decision = 1'b0;
    unique case (mode_q)
      2'b00:   decision = {cnt, 1'b0} > {1'b0, n_en};
      2'b01:   decision = (cnt == n_en);
      2'b10:   decision = (cnt != '0);
      default: decision = (cnt >= thr_q);
    endcase
    if (n_en == '0) decision = 1'b0;
  end

  always_ff @(posedge rx_fifo_clock or negedge rx_fifo_resetn) begin
    if (!rx_fifo_resetn) state_q <= StIdle;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StCollect;
      StCollect: if (coll_done) state_d = StEval;
      StEval:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    en_d          = en_q;
    got_d         = got_q;
    res_d         = res_q;
    mode_d        = mode_q;
    thr_d         = thr_q;
    timer_d       = timer_q;
    vote_result_d = vote_result_q;
    vote_count_d  = vote_count_q;
    timeout_err_d = timeout_err_q;
    vote_valid_d  = (state_q == StEval);
    start_drop_d  = start && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          en_d    = tree_en;
          mode_d  = mode;
          thr_d   = threshold;
          got_d   = tree_valid & tree_en;
          res_d   = tree_result & tree_valid & tree_en;
          timer_d = '0;
        end
      end
      StCollect: begin
        got_d = got_q | capture;
        res_d = (res_q & ~capture) | (tree_result & capture);
        if (!coll_done) timer_d = timer_q + TMO_W'(1);
      end
      StEval: begin
        vote_result_d = decision;
        vote_count_d  = cnt;
        timeout_err_d = (got_q != en_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge rx_fifo_clock or negedge rx_fifo_resetn) begin
    if (!rx_fifo_resetn) begin
      en_q          <= '0;
      got_q         <= '0;
      res_q         <= '0;
      mode_q        <= '0;
      thr_q         <= '0;
      timer_q       <= '0;
      vote_valid_q  <= 1'b0;
      vote_result_q <= 1'b0;
      vote_count_q  <= '0;
      timeout_err_q <= 1'b0;
      start_drop_q  <= 1'b0;
    end else begin
      en_q          <= en_d;
      got_q         <= got_d;
      res_q         <= res_d;
      mode_q        <= mode_d;
      thr_q         <= thr_d;
      timer_q       <= timer_d;
      vote_valid_q  <= vote_valid_d;
      vote_result_q <= vote_result_d;
      vote_count_q  <= vote_count_d;
      timeout_err_q <= timeout_err_d;
      start_drop_q  <= start_drop_d;
    end
  end

  always_comb begin
    busy        = (state_q != StIdle);
    vote_valid  = vote_valid_q;
    vote_result = vote_result_q;
    vote_count  = vote_count_q;
    timeout_err = timeout_err_q;
    start_drop  = start_drop_q;
  end

endmodule

// File: tb/tb_clsf_vote_ensemble.sv
// Bench for clsf_vote_ensemble: two instances (TIMEOUT 16 and 8) share stimulus; a
// transaction-level model is checked every cycle, plus hand-computed directed results.
module tb_clsf_vote_ensemble;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [4:0] tree_en, tree_valid, tree_result;
  logic [1:0] mode;
  logic [2:0] threshold;

  logic       busy_a, vv_a, vr_a, tmo_a, drop_a;
  logic [2:0] cnt_a;
  logic       busy_b, vv_b, vr_b, tmo_b, drop_b;
  logic [2:0] cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  clsf_vote_ensemble #(.NUM_TREES(5), .TIMEOUT(16)) u_dut_a (
    .rx_fifo_clock(clk), .rx_fifo_resetn(rst_n), .start(start), .tree_en(tree_en),
    .mode(mode), .threshold(threshold), .tree_valid(tree_valid), .tree_result(tree_result),
    .busy(busy_a), .vote_valid(vv_a), .vote_result(vr_a), .vote_count(cnt_a),
    .timeout_err(tmo_a), .start_drop(drop_a)
  );

  clsf_vote_ensemble #(.NUM_TREES(5), .TIMEOUT(8)) u_dut_b (
    .rx_fifo_clock(clk), .rx_fifo_resetn(rst_n), .start(start), .tree_en(tree_en),
    .mode(mode), .threshold(threshold), .tree_valid(tree_valid), .tree_result(tree_result),
    .busy(busy_b), .vote_valid(vv_b), .vote_result(vr_b), .vote_count(cnt_b),
    .timeout_err(tmo_b), .start_drop(drop_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model ----------------
  int         ph[2];      // 0 idle, 1 gathering votes, 2 deciding
  logic [4:0] m_en[2], m_got[2], m_res[2];
  logic [1:0] m_mode[2];
  int         m_thr[2], m_n[2];
  int         e_busy[2], e_vv[2], e_vr[2], e_cnt[2], e_tmo[2], e_drop[2];

  function automatic int tmo_of(input int k);
    return (k == 0) ? 16 : 8;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; m_en[k] = '0; m_got[k] = '0; m_res[k] = '0; m_mode[k] = '0;
      m_thr[k] = 0; m_n[k] = 0;
      e_busy[k] = 0; e_vv[k] = 0; e_vr[k] = 0; e_cnt[k] = 0; e_tmo[k] = 0; e_drop[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int  nvv, ndrop, c, ne;
    logic done;
    nvv   = (ph[k] == 2) ? 1 : 0;
    ndrop = (start && ph[k] != 0) ? 1 : 0;
    if (ph[k] == 0) begin
      if (start) begin
        m_en[k] = tree_en; m_mode[k] = mode; m_thr[k] = int'(threshold);
        m_got[k] = tree_valid & tree_en;
        m_res[k] = tree_result & tree_valid & tree_en;
        m_n[k] = 0; ph[k] = 1;
      end
    end else if (ph[k] == 1) begin
      done = (m_got[k] == m_en[k]) || (m_n[k] == tmo_of(k) - 1);
      for (int i = 0; i < 5; i++)
        if (tree_valid[i] && m_en[k][i] && !m_got[k][i]) begin
          m_got[k][i] = 1'b1;
          m_res[k][i] = tree_result[i];
        end
      if (done) ph[k] = 2;
      else m_n[k]++;
    end else begin
      c  = $countones(m_res[k] & m_en[k]);
      ne = $countones(m_en[k]);
      case (m_mode[k])
        2'd0:    e_vr[k] = (2 * c > ne) ? 1 : 0;
        2'd1:    e_vr[k] = (c == ne) ? 1 : 0;
        2'd2:    e_vr[k] = (c != 0) ? 1 : 0;
        default: e_vr[k] = (c >= m_thr[k]) ? 1 : 0;
      endcase
      if (ne == 0) e_vr[k] = 0;
      e_cnt[k] = c;
      e_tmo[k] = (m_got[k] != m_en[k]) ? 1 : 0;
      ph[k] = 0;
    end
    e_vv[k]   = nvv;
    e_drop[k] = ndrop;
    e_busy[k] = (ph[k] != 0) ? 1 : 0;
  endtask

  // Compare at the falling edge, then advance the model with the inputs the next rise samples.
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    chk("a.busy", int'(busy_a), e_busy[0]);  chk("b.busy", int'(busy_b), e_busy[1]);
    chk("a.vote_valid", int'(vv_a), e_vv[0]); chk("b.vote_valid", int'(vv_b), e_vv[1]);
    chk("a.vote_result", int'(vr_a), e_vr[0]); chk("b.vote_result", int'(vr_b), e_vr[1]);
    chk("a.vote_count", int'(cnt_a), e_cnt[0]); chk("b.vote_count", int'(cnt_b), e_cnt[1]);
    chk("a.timeout_err", int'(tmo_a), e_tmo[0]); chk("b.timeout_err", int'(tmo_b), e_tmo[1]);
    chk("a.start_drop", int'(drop_a), e_drop[0]); chk("b.start_drop", int'(drop_b), e_drop[1]);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- directed stimulus ----------------
  logic       st[40];
  logic [4:0] tv[40], tr[40];

  task automatic clr_stim();
    for (int c = 0; c < 40; c++) begin
      st[c] = 1'b0; tv[c] = '0; tr[c] = '0;
    end
    st[0] = 1'b1;
  endtask

  task automatic drive_idle();
    start = 1'b0; tree_valid = '0; tree_result = '0;
  endtask

  // Config is scrambled after cycle 0 to show it only matters when the start is accepted.
  task automatic run(input int which, input logic [4:0] en, input logic [1:0] md,
                     input logic [2:0] thr, output int lat, output int dlat,
                     output int r, output int cnt, output int tmo);
    lat = -1; dlat = -1; r = -1; cnt = -1; tmo = -1;
    for (int c = 0; c < 40; c++) begin
      start = st[c]; tree_valid = tv[c]; tree_result = tr[c];
      tree_en   = (c == 0) ? en : ~en;
      mode      = (c == 0) ? md : md ^ 2'b10;
      threshold = (c == 0) ? thr : ~thr;
      @(posedge clk); #1;
      if (dlat < 0 && ((which == 0) ? drop_a : drop_b)) dlat = c + 1;
      if ((which == 0) ? vv_a : vv_b) begin
        lat = c + 1;
        r   = int'((which == 0) ? vr_a : vr_b);
        cnt = int'((which == 0) ? cnt_a : cnt_b);
        tmo = int'((which == 0) ? tmo_a : tmo_b);
        break;
      end
    end
    drive_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy_a && !busy_b) break;
      @(posedge clk); #1;
    end
    chk("both_idle", int'(busy_a | busy_b), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  int lat, dlat, r, cnt, tmo;

  initial begin
    rst_n = 1'b0; drive_idle(); tree_en = '0; mode = '0; threshold = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", int'(busy_a), 0);
    chk("reset.vote_valid", int'(vv_a), 0);
    chk("reset.vote_count", int'(cnt_a), 0);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Five trees all in the start cycle, majority 3 of 5.
    clr_stim(); tv[0] = 5'b11111; tr[0] = 5'b10110;
    run(0, 5'b11111, 2'b00, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t1.lat", lat, 3); chk("t1.cnt", cnt, 3); chk("t1.res", r, 1); chk("t1.tmo", tmo, 0);

    // Four enabled trees, two votes: tie, OR, AND, threshold 2.
    clr_stim(); tv[0] = 5'b01111; tr[0] = 5'b00011;
    run(0, 5'b01111, 2'b00, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t2.cnt", cnt, 2); chk("t2.maj_tie", r, 0);
    run(0, 5'b01111, 2'b10, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t2.or", r, 1);
    run(0, 5'b01111, 2'b01, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t2.and", r, 0);
    run(0, 5'b01111, 2'b11, 3'd2, lat, dlat, r, cnt, tmo);
    chk("t2.thr", r, 1);

    // Staggered arrivals with a repeat valid on tree 2 (TIMEOUT 16 instance).
    clr_stim();
    tv[0] = 5'b00001; tv[2] = 5'b00010; tv[5] = 5'b01100; tv[7] = 5'b00100; tv[9] = 5'b10000;
    tr[0] = 5'b11111; tr[2] = 5'b11111; tr[5] = 5'b11111; tr[7] = 5'b11011; tr[9] = 5'b11111;
    run(0, 5'b11111, 2'b00, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t3.lat", lat, 12); chk("t3.cnt", cnt, 5); chk("t3.res", r, 1); chk("t3.tmo", tmo, 0);

    // Tree 3 never answers (TIMEOUT 8 instance).
    clr_stim(); tv[0] = 5'b10111; tr[0] = 5'b11111;
    run(1, 5'b11111, 2'b00, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t4.lat", lat, 10); chk("t4.cnt", cnt, 4); chk("t4.res", r, 1); chk("t4.tmo", tmo, 1);

    // No trees enabled, then a single enabled tree in AND mode.
    clr_stim();
    run(0, 5'b00000, 2'b01, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t5.lat", lat, 3); chk("t5.res", r, 0); chk("t5.cnt", cnt, 0);
    clr_stim(); tv[0] = 5'b00100; tr[0] = 5'b00100;
    run(0, 5'b00100, 2'b01, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t5b.cnt", cnt, 1); chk("t5b.res", r, 1);

    // Start while busy is dropped; the in-flight sample keeps its config.
    clr_stim(); st[1] = 1'b1;
    tv[0] = 5'b00011; tr[0] = 5'b00011; tv[2] = 5'b11100; tr[2] = 5'b00000;
    run(0, 5'b11111, 2'b00, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t6.drop_at", dlat, 2); chk("t6.lat", lat, 5); chk("t6.cnt", cnt, 2);
    chk("t6.res", r, 0);

    // Reset in the middle of collection.
    start = 1'b1; tree_en = 5'b11111; mode = 2'b00; tree_valid = 5'b00001; tree_result = 5'b00001;
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t7.busy", int'(busy_a | busy_b), 0);
    chk("t7.cnt", int'(cnt_a), 0);
    chk("t7.valid", int'(vv_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    clr_stim(); tv[0] = 5'b11111; tr[0] = 5'b10110;
    run(0, 5'b11111, 2'b00, 3'd0, lat, dlat, r, cnt, tmo);
    chk("t8.lat", lat, 3); chk("t8.cnt", cnt, 3); chk("t8.res", r, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
